la_dsync_filt: RTL and testbench
================================

Name: la_dsync_filt

Overview:
- Parametrised multi-bit successor to the single-bit data synchronizer.
- Per-bit: a STAGES-deep metastability chain, an optional persistence (glitch) filter, and registered-output edge detection.
- Placed at asynchronous input boundaries: GPIO, straps, status lines from other clock domains.
- Each bit is independent. Multi-bit coherency is not guaranteed; gray-coded or quasi-static inputs only.

Parameters:
- PROP, "DEFAULT", cell/implementation selector passed to the technology mapping.
- WIDTH, 1, number of independent bits synchronized.
- STAGES, 2, synchronizer depth. Minimum 2; values below 2 abort elaboration.
- FILTER, 0, persistence count. 0 = filter bypassed; N>0 = synced value must differ from out for N consecutive cycles before out updates.
- RSTVAL, 0, WIDTH-bit value loaded into all chain stages, out and the previous-out register on reset.

Ports:
- clk  input  1  destination clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  asynchronous input bits.
- out  output  WIDTH  synchronized, filtered data.
- rise  output  WIDTH  one-cycle pulse per bit on out 0->1.
- fall  output  WIDTH  one-cycle pulse per bit on out 1->0.
- changed  output  1  OR-reduction of (rise | fall).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates occur on posedge clk only.
- Reset (rst=1 at a posedge):
  - All chain stages = RSTVAL; out = RSTVAL; previous-out register = RSTVAL.
  - All filter counters = 0.
  - rise = fall = 0; changed = 0.
  - rst has priority over every other event.
- Chain: stage[0] <= in; stage[k] <= stage[k-1]; sync = stage[STAGES-1]. Chain flops are library DFF cells selected via PROP, with the reset mux on D.
- FILTER=0:
  - out = sync, no extra register.
  - Latency: a change in in, stable before edge e0, appears on out after edge e(STAGES-1), i.e. STAGES edges.
- FILTER>0: per bit, a counter cnt of width clog2(FILTER+1) and a register out_q; out = out_q.
  - sync[i]==out_q[i]: cnt <= 0.
  - else if cnt==FILTER-1: out_q <= sync[i], cnt <= 0.
  - else: cnt <= cnt+1.
  - Latency for a sustained change = STAGES+FILTER edges.
  - A sync pulse shorter than FILTER cycles: counter returns to 0, out unchanged, no edge pulse.
  - Counter never exceeds FILTER-1; no wrap.
- Edge detect:
  - prev <= out every cycle.
  - rise = out & ~prev; fall = ~out & prev. Combinational from registers, glitch-free.
  - A pulse is high exactly the first cycle out shows the new value.
  - No pulse in the first cycle after reset, because prev = out = RSTVAL.
- Simultaneous events:
  - Different bits update independently in the same cycle; changed asserts once.
  - Input toggling every cycle with FILTER>=2: out never changes.
- Reset mid-filter: a partial count is discarded; the value in flight is lost; after release the chain refills from in.

Test Plan:
- WIDTH=4, STAGES=2, FILTER=0, RSTVAL=4'hA: hold rst 3 cycles with in=4'h5 -> out=4'hA, rise=fall=0 during reset. Release -> out=4'h5 on the 2nd posedge after release; that cycle rise=4'h5, fall=4'hA, changed=1; next cycle all pulses 0.
- STAGES=3, FILTER=4, WIDTH=1, RSTVAL=0: in 0->1 held -> out rises exactly 7 edges after the capture edge; rise high 1 cycle.
- Same config: in high for 3 cycles, then low -> out stays 0, rise never asserts, internal cnt returns to 0.
- FILTER=2: in toggles every cycle for 20 cycles -> out constant, changed=0 throughout.
- WIDTH=2: bit0 rises and bit1 falls at the same edge -> rise=2'b01, fall=2'b10 in the same cycle, changed=1 for one cycle.
- FILTER=4: assert rst when cnt=3 on a pending change -> next cycle out=RSTVAL, cnt=0, no pulse. After release with in unchanged -> full STAGES+FILTER latency again.

Source files
------------

// File: rtl/la_dsync_filt.sv
// Multi-bit input synchronizer: per-bit metastability chain, optional persistence
// filter and registered-output edge detection. Bits are independent; no coherency.
module la_dsync_filt #(
  parameter string             PROP   = "DEFAULT",
  parameter int                WIDTH  = 1,
  parameter int                STAGES = 2,
  parameter int                FILTER = 0,
  parameter logic [WIDTH-1:0]  RSTVAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  genvar gi;

  if (STAGES < 2) begin : g_bad_stages
    $error("la_dsync_filt: STAGES must be at least 2");
  end

  // PROP names the cell family the chain flops are mapped onto.
  if (PROP == "") begin : g_bad_prop
    $error("la_dsync_filt: PROP must name a synchronizer cell family");
  end

  logic [WIDTH-1:0] stage_reg [STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_reg;

  // Reset is muxed onto D so the chain maps onto plain DFF cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_reg[k] <= RSTVAL;
      end
    end else begin
      stage_reg[0] <= in;
      for (int k = 1; k < STAGES; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign sync = stage_reg[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    assign out = sync;
  end else begin : g_filt
    localparam int                CNT_W    = $clog2(FILTER + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER - 1);

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             out_reg;

      // Counter only runs while sync disagrees with out, so any agreement
      // (a glitch ending) discards the partial count.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
          out_reg <= RSTVAL[gi];
        end else if (sync[gi] == out_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          out_reg <= sync[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign out[gi] = out_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= RSTVAL;
    end else begin
      prev_reg <= out;
    end
  end

  // Both operands are flop outputs, so the pulses cannot glitch.
  assign rise    = out & ~prev_reg;
  assign fall    = ~out & prev_reg;
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_la_dsync_filt.sv
// Directed bench for la_dsync_filt across four configurations sharing one clock.
module tb_la_dsync_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // A: WIDTH=4 STAGES=2 FILTER=0 RSTVAL=A
  logic       rst_a = 1'b1;
  logic [3:0] in_a = 4'h0, out_a, rise_a, fall_a;
  logic       chg_a;
  // B: WIDTH=1 STAGES=3 FILTER=4 RSTVAL=0
  logic       rst_b = 1'b1;
  logic [0:0] in_b = 1'b0, out_b, rise_b, fall_b;
  logic       chg_b;
  // C: WIDTH=1 STAGES=2 FILTER=2 RSTVAL=0
  logic       rst_c = 1'b1;
  logic [0:0] in_c = 1'b0, out_c, rise_c, fall_c;
  logic       chg_c;
  // D: WIDTH=2 STAGES=2 FILTER=0 RSTVAL=0
  logic       rst_d = 1'b1;
  logic [1:0] in_d = 2'b00, out_d, rise_d, fall_d;
  logic       chg_d;

  la_dsync_filt #(.PROP("DEFAULT"), .WIDTH(4), .STAGES(2), .FILTER(0), .RSTVAL(4'hA)) dut_a (
    .clk(clk), .rst(rst_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));
  la_dsync_filt #(.PROP("DEFAULT"), .WIDTH(1), .STAGES(3), .FILTER(4), .RSTVAL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));
  la_dsync_filt #(.PROP("DEFAULT"), .WIDTH(1), .STAGES(2), .FILTER(2), .RSTVAL(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));
  la_dsync_filt #(.PROP("DEFAULT"), .WIDTH(2), .STAGES(2), .FILTER(0), .RSTVAL(2'b00)) dut_d (
    .clk(clk), .rst(rst_d), .in(in_d), .out(out_d), .rise(rise_d), .fall(fall_d), .changed(chg_d));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_b;
    rst_b = 1'b1;
    in_b  = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    in_a  = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_a, rise_a, fall_a, chg_a} !== {4'hA, 4'h0, 4'h0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: out/rise/fall/chg got %h/%h/%h/%b expected a/0/0/0",
                 i, out_a, rise_a, fall_a, chg_a);
      end
    end
    rst_a = 1'b0;
    tick();
    n_cmp++;
    if ({out_a, rise_a, fall_a, chg_a} !== {4'hA, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_rel1: out/rise/fall/chg got %h/%h/%h/%b expected a/0/0/0",
               out_a, rise_a, fall_a, chg_a);
    end
    tick();
    n_cmp++;
    if ({out_a, rise_a, fall_a, chg_a} !== {4'h5, 4'h5, 4'hA, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_rel2: out/rise/fall/chg got %h/%h/%h/%b expected 5/5/a/1",
               out_a, rise_a, fall_a, chg_a);
    end
    tick();
    n_cmp++;
    if ({out_a, rise_a, fall_a, chg_a} !== {4'h5, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_rel3: out/rise/fall/chg got %h/%h/%h/%b expected 5/0/0/0",
               out_a, rise_a, fall_a, chg_a);
    end
    $display("test_reset: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_latency;
    reset_b();
    in_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      logic exp_out, exp_rise;
      exp_out  = (e >= 7);
      exp_rise = (e == 7);
      tick();
      n_cmp++;
      if ({out_b, rise_b} !== {exp_out, exp_rise}) begin
        n_bad++;
        $display("FAIL latency_e%0d: out/rise got %b/%b expected %b/%b",
                 e, out_b, rise_b, exp_out, exp_rise);
      end
    end
    $display("test_latency: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_glitch;
    reset_b();
    in_b = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) in_b = 1'b0;
      tick();
      n_cmp++;
      if ({out_b, rise_b, chg_b} !== 3'b000) begin
        n_bad++;
        $display("FAIL glitch_c%0d: out/rise/chg got %b/%b/%b expected 0/0/0",
                 c, out_b, rise_b, chg_b);
      end
    end
    // A leftover count would make this sustained change land early.
    in_b = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      logic exp_out;
      exp_out = (e == 7);
      tick();
      n_cmp++;
      if ({out_b, rise_b} !== {exp_out, exp_out}) begin
        n_bad++;
        $display("FAIL glitch_after_e%0d: out/rise got %b/%b expected %b/%b",
                 e, out_b, rise_b, exp_out, exp_out);
      end
    end
    $display("test_glitch: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_reset_mid;
    reset_b();
    in_b = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_cmp++;
      if (out_b !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_pre_e%0d: out got %b expected 0", e, out_b);
      end
    end
    rst_b = 1'b1;
    tick();
    n_cmp++;
    if ({out_b, rise_b, fall_b, chg_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_rst: out/rise/fall/chg got %b/%b/%b/%b expected 0/0/0/0",
               out_b, rise_b, fall_b, chg_b);
    end
    rst_b = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      logic exp_out;
      exp_out = (e == 7);
      tick();
      n_cmp++;
      if ({out_b, rise_b} !== {exp_out, exp_out}) begin
        n_bad++;
        $display("FAIL midrst_post_e%0d: out/rise got %b/%b expected %b/%b",
                 e, out_b, rise_b, exp_out, exp_out);
      end
    end
    $display("test_reset_mid: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_toggle;
    rst_c = 1'b1;
    in_c  = 1'b0;
    tick();
    tick();
    rst_c = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_c = ~in_c;
      tick();
      n_cmp++;
      if ({out_c, chg_c} !== 2'b00) begin
        n_bad++;
        $display("FAIL toggle_c%0d: out/chg got %b/%b expected 0/0", c, out_c, chg_c);
      end
    end
    in_c = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      logic exp_out;
      exp_out = (e == 4);
      tick();
      n_cmp++;
      if ({out_c, chg_c} !== {exp_out, exp_out}) begin
        n_bad++;
        $display("FAIL toggle_hold_e%0d: out/chg got %b/%b expected %b/%b",
                 e, out_c, chg_c, exp_out, exp_out);
      end
    end
    $display("test_toggle: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_simultaneous;
    rst_d = 1'b1;
    in_d  = 2'b00;
    tick();
    tick();
    rst_d = 1'b0;
    in_d  = 2'b10;
    tick();
    n_cmp++;
    if ({out_d, chg_d} !== 3'b000) begin
      n_bad++;
      $display("FAIL simul_setup1: out/chg got %b/%b expected 00/0", out_d, chg_d);
    end
    tick();
    n_cmp++;
    if ({out_d, rise_d, fall_d, chg_d} !== {2'b10, 2'b10, 2'b00, 1'b1}) begin
      n_bad++;
      $display("FAIL simul_setup2: out/rise/fall/chg got %b/%b/%b/%b expected 10/10/00/1",
               out_d, rise_d, fall_d, chg_d);
    end
    in_d = 2'b01;
    tick();
    n_cmp++;
    if ({out_d, chg_d} !== 3'b100) begin
      n_bad++;
      $display("FAIL simul_wait: out/chg got %b/%b expected 10/0", out_d, chg_d);
    end
    tick();
    n_cmp++;
    if ({out_d, rise_d, fall_d, chg_d} !== {2'b01, 2'b01, 2'b10, 1'b1}) begin
      n_bad++;
      $display("FAIL simul_edge: out/rise/fall/chg got %b/%b/%b/%b expected 01/01/10/1",
               out_d, rise_d, fall_d, chg_d);
    end
    tick();
    n_cmp++;
    if ({out_d, rise_d, fall_d, chg_d} !== {2'b01, 2'b00, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL simul_after: out/rise/fall/chg got %b/%b/%b/%b expected 01/00/00/0",
               out_d, rise_d, fall_d, chg_d);
    end
    $display("test_simultaneous: done, %0d compared so far", n_cmp);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_reset_mid();
    test_toggle();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
